pipeline_stall_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage MIPS pipeline. It detects RAW hazards between the instruction in ID and the destinations in EXE/MEM. It holds the whole pipeline while a MEM-stage SRAM access waits for ready, and it flushes IF on taken branches. Its outputs drive the ID-stage freeze bubble mux, the IF/PC hold and the pipeline register enables. It also keeps a small wait-timeout FSM and performance counters.

---
 rtl/pipeline_stall_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush scheduler for a 5-stage MIPS pipeline.
// Detects ID-stage RAW hazards against the EXE/MEM destinations, holds the
// whole pipeline while a MEM-stage SRAM access waits for ready, flushes IF on
// taken branches, and keeps a wait-timeout FSM plus saturating perf counters.
module pipeline_stall_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_valid,
    input  logic [4:0]       src1,
    input  logic [4:0]       src2,
    input  logic             is_single_src,
    input  logic             is_BNE,
    input  logic             forward_en,
    input  logic [4:0]       EXE_Dest,
    input  logic             EXE_WB_EN,
    input  logic             EXE_MEM_R_EN,
    input  logic [4:0]       MEM_Dest,
    input  logic             MEM_WB_EN,
    input  logic             MEM_access,
    input  logic             sram_ready,
    input  logic             Br_taken,
    output logic             freeze_ID,
    output logic             freeze_IF,
    output logic             pipe_hold,
    output logic             IF_flush,
    output logic             err_timeout,
    output logic [CNT_W-1:0] hazard_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    // Wide enough to hold TIMEOUT-1 and its increment without overflow.
    localparam int unsigned WCW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WCW-1:0]   r_wait_cnt;
    logic [WCW-1:0]   w_wait_nxt;
    logic [CNT_W-1:0] r_hazard_cnt;
    logic [CNT_W-1:0] r_memwait_cnt;

    logic w_pipe_hold;
    logic w_haz_src1;
    logic w_haz_src2;
    logic w_use_src2;
    logic w_hazard;
    logic w_freeze_ID;

    // Per-source RAW hazard: a load in EXE always stalls; any EXE/MEM producer
    // stalls when forwarding is disabled. r0 never carries a dependency.
    always_comb begin
        w_haz_src1 = 1'b0;
        w_haz_src2 = 1'b0;
        if (src1 != 5'd0) begin
            w_haz_src1 = (EXE_WB_EN & (EXE_Dest == src1) & (~forward_en | EXE_MEM_R_EN))
                       | (~forward_en & MEM_WB_EN & (MEM_Dest == src1));
        end
        if (src2 != 5'd0) begin
            w_haz_src2 = (EXE_WB_EN & (EXE_Dest == src2) & (~forward_en | EXE_MEM_R_EN))
                       | (~forward_en & MEM_WB_EN & (MEM_Dest == src2));
        end
    end

    assign w_use_src2 = ~is_single_src | is_BNE;
    assign w_hazard   = ID_valid & ~Br_taken & (w_haz_src1 | (w_use_src2 & w_haz_src2));

    // Wait FSM next-state and hold decode.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_pipe_hold = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                w_pipe_hold = MEM_access & ~sram_ready;
                if (w_pipe_hold) begin
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = WCW'(1);
                end
            end
            ST_MEM_WAIT: begin
                w_pipe_hold = ~sram_ready;
                if (sram_ready) begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end else begin
                    w_wait_nxt = r_wait_cnt + WCW'(1);
                    if (r_wait_cnt == WCW'(TIMEOUT - 1)) begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                w_pipe_hold = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Bubbles are only meaningful when the pipeline actually advances.
    assign w_freeze_ID = w_hazard & ~w_pipe_hold;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hazard_cnt  <= '0;
            r_memwait_cnt <= '0;
        end else begin
            if (w_freeze_ID && (r_hazard_cnt != '1)) begin
                r_hazard_cnt <= r_hazard_cnt + CNT_W'(1);
            end
            if (w_pipe_hold && (r_memwait_cnt != '1)) begin
                r_memwait_cnt <= r_memwait_cnt + CNT_W'(1);
            end
        end
    end

    assign freeze_ID   = w_freeze_ID;
    assign freeze_IF   = w_hazard | w_pipe_hold;
    assign pipe_hold   = w_pipe_hold;
    assign IF_flush    = Br_taken & ~w_pipe_hold;
    assign err_timeout = (r_state == ST_ERR);
    assign hazard_cnt  = r_hazard_cnt;
    assign memwait_cnt = r_memwait_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a model.
module tb_pipeline_stall_ctrl;

    localparam int TO = 5;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ID_valid, is_single_src, is_BNE, forward_en;
    logic [4:0]    src1, src2, EXE_Dest, MEM_Dest;
    logic          EXE_WB_EN, EXE_MEM_R_EN, MEM_WB_EN;
    logic          MEM_access, sram_ready, Br_taken;
    logic          freeze_ID, freeze_IF, pipe_hold, IF_flush, err_timeout;
    logic [CW-1:0] hazard_cnt, memwait_cnt;

    int n_pass  = 0;
    int n_total = 0;

    pipeline_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ID_valid(ID_valid), .src1(src1), .src2(src2),
        .is_single_src(is_single_src), .is_BNE(is_BNE), .forward_en(forward_en),
        .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN),
        .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN), .MEM_access(MEM_access),
        .sram_ready(sram_ready), .Br_taken(Br_taken), .freeze_ID(freeze_ID),
        .freeze_IF(freeze_IF), .pipe_hold(pipe_hold), .IF_flush(IF_flush),
        .err_timeout(err_timeout), .hazard_cnt(hazard_cnt), .memwait_cnt(memwait_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model state: consecutive hold cycles of the current wait, error flag, counters.
    bit m_valid = 0;
    bit m_err   = 0;
    int m_run   = 0;
    int m_hcnt  = 0;
    int m_wcnt  = 0;

    function automatic bit dep(input logic [4:0] s);
        if (s == 0) return 0;
        if (EXE_WB_EN && EXE_Dest == s && (!forward_en || EXE_MEM_R_EN)) return 1;
        if (!forward_en && MEM_WB_EN && MEM_Dest == s) return 1;
        return 0;
    endfunction

    // Compare DUT against the model mid-cycle, then advance the model.
    always @(negedge clk) begin
        bit hz, hold, e_fid, e_fif, e_flush;
        hz = ID_valid && !Br_taken && (dep(src1) || ((!is_single_src || is_BNE) && dep(src2)));
        if (m_err)          hold = 1;
        else if (m_run > 0) hold = !sram_ready;
        else                hold = MEM_access && !sram_ready;
        e_fid   = hz && !hold;
        e_fif   = hz || hold;
        e_flush = Br_taken && !hold;
        if (m_valid) begin
            chk("m_freeze_ID",   int'(freeze_ID),   int'(e_fid));
            chk("m_freeze_IF",   int'(freeze_IF),   int'(e_fif));
            chk("m_pipe_hold",   int'(pipe_hold),   int'(hold));
            chk("m_IF_flush",    int'(IF_flush),    int'(e_flush));
            chk("m_err_timeout", int'(err_timeout), int'(m_err));
            chk("m_hazard_cnt",  int'(hazard_cnt),  m_hcnt);
            chk("m_memwait_cnt", int'(memwait_cnt), m_wcnt);
        end
        if (rst) begin
            m_valid = 1; m_err = 0; m_run = 0; m_hcnt = 0; m_wcnt = 0;
        end else begin
            if (e_fid) m_hcnt = (m_hcnt + 1 > CMAX) ? CMAX : m_hcnt + 1;
            if (hold)  m_wcnt = (m_wcnt + 1 > CMAX) ? CMAX : m_wcnt + 1;
            if (!m_err) begin
                if (hold) begin
                    m_run++;
                    if (m_run >= TO) m_err = 1;
                end else begin
                    m_run = 0;
                end
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #2;
    endtask

    task automatic idle();
        rst = 0; ID_valid = 0; src1 = 0; src2 = 0; is_single_src = 0; is_BNE = 0;
        forward_en = 0; EXE_Dest = 0; EXE_WB_EN = 0; EXE_MEM_R_EN = 0;
        MEM_Dest = 0; MEM_WB_EN = 0; MEM_access = 0; sram_ready = 0; Br_taken = 0;
    endtask

    task automatic set_exe_hazard();
        ID_valid = 1; forward_en = 0; is_single_src = 1; src1 = 3;
        EXE_Dest = 3; EXE_WB_EN = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        next_cyc();
        next_cyc();
        settle();
        chk("rst_hazard_cnt",  int'(hazard_cnt),  0);
        chk("rst_memwait_cnt", int'(memwait_cnt), 0);
        chk("rst_err",         int'(err_timeout), 0);
        chk("rst_pipe_hold",   int'(pipe_hold),   0);
        next_cyc();
        rst = 0;

        // EXE producer, no forwarding
        set_exe_hazard();
        settle();
        chk("exe_freeze_ID", int'(freeze_ID), 1);
        chk("exe_freeze_IF", int'(freeze_IF), 1);
        chk("exe_hcnt_pre",  int'(hazard_cnt), 0);
        next_cyc();
        src1 = 0;
        settle();
        chk("r0_freeze_ID", int'(freeze_ID), 0);
        chk("r0_freeze_IF", int'(freeze_IF), 0);
        chk("exe_hcnt_post", int'(hazard_cnt), 1);

        // forwarding enabled: only loads stall
        next_cyc();
        forward_en = 1; EXE_MEM_R_EN = 1; EXE_Dest = 5; src1 = 5; src2 = 6; is_single_src = 0;
        settle();
        chk("load_use_freeze", int'(freeze_ID), 1);
        next_cyc();
        EXE_MEM_R_EN = 0;
        settle();
        chk("fwd_alu_freeze", int'(freeze_ID), 0);
        next_cyc();
        EXE_WB_EN = 0; MEM_WB_EN = 1; MEM_Dest = 5;
        settle();
        chk("fwd_mem_freeze", int'(freeze_ID), 0);

        // single-source vs BNE on src2
        next_cyc();
        MEM_WB_EN = 0; EXE_WB_EN = 1; EXE_Dest = 7; src1 = 1; src2 = 7;
        is_single_src = 1; forward_en = 0;
        settle();
        chk("single_src2_freeze", int'(freeze_ID), 0);
        next_cyc();
        is_BNE = 1;
        settle();
        chk("bne_src2_freeze", int'(freeze_ID), 1);
        chk("hcnt_three_pre", int'(hazard_cnt), 2);

        // 4-cycle SRAM wait with a pending hazard
        next_cyc();
        idle(); rst = 1;
        next_cyc();
        rst = 0; MEM_access = 1; sram_ready = 0;
        set_exe_hazard();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("wait_pipe_hold", int'(pipe_hold), 1);
            chk("wait_freeze_ID", int'(freeze_ID), 0);
            chk("wait_freeze_IF", int'(freeze_IF), 1);
            next_cyc();
        end
        sram_ready = 1; ID_valid = 0;
        settle();
        chk("ready_pipe_hold", int'(pipe_hold), 0);
        next_cyc();
        idle();
        settle();
        chk("wait_memwait_cnt", int'(memwait_cnt), 4);
        chk("wait_hazard_cnt",  int'(hazard_cnt),  0);
        chk("wait_err",         int'(err_timeout), 0);

        // branch vs hazard, branch during hold
        next_cyc();
        set_exe_hazard(); Br_taken = 1;
        settle();
        chk("br_flush",     int'(IF_flush),  1);
        chk("br_freeze_ID", int'(freeze_ID), 0);
        chk("br_freeze_IF", int'(freeze_IF), 0);
        next_cyc();
        MEM_access = 1; sram_ready = 0;
        settle();
        chk("br_hold_flush", int'(IF_flush),  0);
        chk("br_hold_hold",  int'(pipe_hold), 1);
        next_cyc();
        sram_ready = 1;
        settle();
        chk("br_release_flush", int'(IF_flush), 1);

        // timeout into sticky error, saturation, reset recovery
        next_cyc();
        idle(); rst = 1;
        next_cyc();
        rst = 0; MEM_access = 1; sram_ready = 0;
        for (int i = 0; i < TO; i++) begin
            settle();
            chk("to_pipe_hold", int'(pipe_hold),   1);
            chk("to_err_early", int'(err_timeout), 0);
            next_cyc();
        end
        MEM_access = 0; sram_ready = 1;
        settle();
        chk("to_err",       int'(err_timeout), 1);
        chk("to_err_hold",  int'(pipe_hold),   1);
        chk("to_memwait",   int'(memwait_cnt), TO);
        repeat (12) next_cyc();
        settle();
        chk("sat_memwait", int'(memwait_cnt), CMAX);
        chk("sat_err",     int'(err_timeout), 1);
        next_cyc();
        rst = 1;
        next_cyc();
        rst = 0; sram_ready = 0;
        settle();
        chk("rec_err",      int'(err_timeout), 0);
        chk("rec_memwait",  int'(memwait_cnt), 0);
        chk("rec_hazard",   int'(hazard_cnt),  0);
        chk("rec_hold",     int'(pipe_hold),   0);

        // randomized traffic, model-checked each cycle
        for (int c = 0; c < 3000; c++) begin
            next_cyc();
            rst           = ($urandom_range(0, 199) == 0);
            ID_valid      = ($urandom_range(0, 9) < 8);
            src1          = 5'($urandom_range(0, 3));
            src2          = 5'($urandom_range(0, 3));
            is_single_src = $urandom_range(0, 1) != 0;
            is_BNE        = ($urandom_range(0, 4) == 0);
            forward_en    = $urandom_range(0, 1) != 0;
            EXE_Dest      = 5'($urandom_range(0, 3));
            EXE_WB_EN     = $urandom_range(0, 1) != 0;
            EXE_MEM_R_EN  = ($urandom_range(0, 2) == 0);
            MEM_Dest      = 5'($urandom_range(0, 3));
            MEM_WB_EN     = $urandom_range(0, 1) != 0;
            MEM_access    = ($urandom_range(0, 2) == 0);
            sram_ready    = ($urandom_range(0, 9) < 6);
            Br_taken      = ($urandom_range(0, 7) == 0);
        end
        next_cyc();
        idle();
        next_cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
